// File: rtl/gmii_rx_frame_ctrl.sv
// gmii_rx_frame_ctrl
// GMII receive framer: strips preamble/SFD, holds back the trailing FCS through
// a 5-byte delay line, checks CRC-32 against the residue and enforces length
// limits. Emits a byte stream without backpressure plus saturating per-frame
// statistics.
module gmii_rx_frame_ctrl #(
   parameter int MIN_FRAME    = 64,
   parameter int MAX_FRAME    = 1522,
   parameter int MAX_PREAMBLE = 15,
   parameter int CNT_W        = 16
) (
   input  logic             gmii_rx_clk,
   input  logic             rst,
   input  logic             gmii_rx_dv,
   input  logic [7:0]       gmii_rxd,
   input  logic             gmii_rx_er,
   output logic [7:0]       m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   output logic             m_tuser,
   output logic [CNT_W-1:0] stat_ok,
   output logic [CNT_W-1:0] stat_err,
   output logic [CNT_W-1:0] stat_drop
);

   localparam int LEN_W = $clog2(MAX_FRAME + 2);
   localparam int PRE_W = $clog2(MAX_PREAMBLE + 2);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_FRAME);
   localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME);
   // FCS is 4 bytes, so a fifth held byte means the oldest one is payload
   localparam logic [LEN_W-1:0] LEN_HOLD = LEN_W'(5);
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(MAX_PREAMBLE);
   localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

   state_t            state_q;
   logic [PRE_W-1:0]  pre_cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic [31:0]       crc_q;
   logic              err_q;
   logic [4:0][7:0]   dly_q;     // [0] newest, [4] oldest held byte
   logic [31:0]       crc_d;
   logic              frame_bad;

   // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Statistics counters stick at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign crc_d     = crc32_byte(crc_q, gmii_rxd);
   assign frame_bad = err_q | (len_q < LEN_MIN) | (crc_q != CRC_RESIDUE);

   // Frame FSM with registered stream outputs and statistics
   always_ff @(posedge gmii_rx_clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pre_cnt_q <= '0;
         len_q     <= '0;
         crc_q     <= '1;
         err_q     <= 1'b0;
         dly_q     <= '0;
         m_tdata   <= '0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_tuser   <= 1'b0;
         stat_ok   <= '0;
         stat_err  <= '0;
         stat_drop <= '0;
      end else begin
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // dv=0 cycles (including carrier extension) are ignored here
               if (gmii_rx_dv) begin
                  if (gmii_rxd == 8'h55 && !gmii_rx_er) begin
                     state_q   <= S_PRE;
                     pre_cnt_q <= PRE_W'(1);
                  end else begin
                     state_q   <= S_DROP;
                     stat_drop <= sat_inc(stat_drop);
                  end
               end
            end
            S_PRE: begin
               if (!gmii_rx_dv) begin
                  state_q   <= S_IDLE;
                  stat_drop <= sat_inc(stat_drop);
               end else if (!gmii_rx_er && gmii_rxd == 8'h55 && pre_cnt_q != PRE_MAX) begin
                  pre_cnt_q <= pre_cnt_q + PRE_W'(1);
               end else if (!gmii_rx_er && gmii_rxd == 8'hD5) begin
                  state_q <= S_DATA;
                  len_q   <= '0;
                  crc_q   <= '1;
                  err_q   <= 1'b0;
               end else begin
                  state_q   <= S_DROP;
                  stat_drop <= sat_inc(stat_drop);
               end
            end
            S_DATA: begin
               if (gmii_rx_dv) begin
                  dly_q <= {dly_q[3:0], gmii_rxd};
                  len_q <= len_q + LEN_W'(1);
                  crc_q <= crc_d;
                  if (gmii_rx_er) err_q <= 1'b1;
                  if (len_q >= LEN_HOLD) begin
                     m_tvalid <= 1'b1;
                     m_tdata  <= dly_q[4];
                  end
                  // this byte makes the frame one longer than allowed
                  if (len_q == LEN_MAX) begin
                     m_tlast  <= 1'b1;
                     m_tuser  <= 1'b1;
                     stat_err <= sat_inc(stat_err);
                     state_q  <= S_DROP;
                  end
               end else begin
                  // the four bytes left in the delay line are the FCS
                  if (len_q >= LEN_HOLD) begin
                     m_tvalid <= 1'b1;
                     m_tlast  <= 1'b1;
                     m_tuser  <= frame_bad;
                     m_tdata  <= dly_q[4];
                     if (frame_bad) stat_err <= sat_inc(stat_err);
                     else           stat_ok  <= sat_inc(stat_ok);
                  end else begin
                     stat_drop <= sat_inc(stat_drop);
                  end
                  state_q <= S_IDLE;
               end
            end
            S_DROP: begin
               if (!gmii_rx_dv) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Testbench for gmii_rx_frame_ctrl: directed and randomized GMII bursts, each
// burst translated by a frame-level reference model into expected beats and
// statistics.
module tb_gmii_rx_frame_ctrl;

   localparam int MIN_F   = 64;
   localparam int MAX_F   = 1522;
   localparam int MAX_PRE = 15;
   localparam int CW      = 4;
   localparam int CMAX    = (1 << CW) - 1;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dv  = 1'b0;
   logic          er  = 1'b0;
   logic [7:0]    rxd = 8'h00;
   logic [7:0]    m_tdata;
   logic          m_tvalid, m_tlast, m_tuser;
   logic [CW-1:0] stat_ok, stat_err, stat_drop;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int idle_viol = 0;
   int exp_ok = 0, exp_err = 0, exp_drop = 0;
   logic [9:0] gotq[$];
   logic [9:0] expq[$];
   int         gcyc[$];
   logic [7:0] bq[$];
   bit         erq[$];
   int         post_start = -1;
   int         first_cyc  = 0;

   gmii_rx_frame_ctrl #(
      .MIN_FRAME(MIN_F), .MAX_FRAME(MAX_F), .MAX_PREAMBLE(MAX_PRE), .CNT_W(CW)
   ) dut (
      .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd), .gmii_rx_er(er),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
      .stat_ok(stat_ok), .stat_err(stat_err), .stat_drop(stat_drop)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Beat monitor, sampled just after the active edge
   always @(posedge clk) begin
      #1;
      if (m_tvalid) begin
         gotq.push_back({m_tdata, m_tlast, m_tuser});
         gcyc.push_back(cyc);
      end else if (m_tlast || m_tuser) begin
         idle_viol++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // Bitwise reflected CRC-32 over a byte list
   function automatic logic [31:0] crc_ref(input logic [7:0] d[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         for (int k = 0; k < 8; k++) begin
            logic fb;
            fb = c[0] ^ d[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return c;
   endfunction

   // Frame-level model: one dv=1 burst starting from idle
   task automatic model_burst(input logic [7:0] b[$], input bit e[$]);
      int n = b.size();
      int i = 0;
      int L;
      bit anyer = 0;
      bit bad;
      logic [7:0] post[$];
      while (i < n && b[i] == 8'h55 && !e[i]) i++;
      if (i == 0 || i > MAX_PRE || i == n || b[i] != 8'hD5 || e[i]) begin
         exp_drop = sat(exp_drop);
         return;
      end
      for (int j = i + 1; j < n; j++) begin
         post.push_back(b[j]);
         anyer |= e[j];
      end
      L = post.size();
      if (L > MAX_F) begin
         for (int j = 0; j < MAX_F - 4; j++)
            expq.push_back({post[j], j == MAX_F - 5, j == MAX_F - 5});
         exp_err = sat(exp_err);
      end else if (L <= 4) begin
         exp_drop = sat(exp_drop);
      end else begin
         bad = anyer || (L < MIN_F) || (crc_ref(post) != RESIDUE);
         for (int j = 0; j <= L - 5; j++)
            expq.push_back({post[j], j == L - 5, bad && (j == L - 5)});
         if (bad) exp_err = sat(exp_err);
         else     exp_ok  = sat(exp_ok);
      end
   endtask

   task automatic build_frame(input int npre, input int nbody, input bit fcs_ok, input int er_at);
      logic [7:0] body[$];
      logic [31:0] fcs;
      bq.delete();
      erq.delete();
      repeat (npre) begin bq.push_back(8'h55); erq.push_back(0); end
      bq.push_back(8'hD5); erq.push_back(0);
      post_start = npre + 1;
      repeat (nbody) body.push_back(8'($urandom));
      fcs = ~crc_ref(body);
      foreach (body[i]) begin bq.push_back(body[i]); erq.push_back(0); end
      for (int k = 0; k < 4; k++) begin bq.push_back(fcs[8*k +: 8]); erq.push_back(0); end
      if (!fcs_ok) bq[bq.size()-1] = bq[bq.size()-1] ^ 8'h01;
      if (er_at >= 0) erq[npre + 1 + er_at] = 1;
   endtask

   task automatic send_burst();
      for (int i = 0; i < bq.size(); i++) begin
         @(negedge clk);
         dv = 1'b1; rxd = bq[i]; er = erq[i];
         if (i == post_start) first_cyc = cyc;
      end
      model_burst(bq, erq);
      @(negedge clk);
      dv = 1'b0; rxd = 8'($urandom); er = 1'($urandom);
   endtask

   task automatic clear_exp();
      gotq.delete(); expq.delete(); gcyc.delete();
      exp_ok = 0; exp_err = 0; exp_drop = 0; idle_viol = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      dv = 1'b0; er = 1'b0;
      #1 rst = 1'b1;
      #1 check("rst_state", {m_tvalid, m_tlast, m_tuser, m_tdata, stat_ok, stat_err, stat_drop}, 0);
      clear_exp();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic checkpoint(input string name);
      int nmis = 0;
      int first = -1;
      repeat (8) @(negedge clk);
      er = 1'b0;
      for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
         if (gotq[i] !== expq[i]) begin
            nmis++;
            if (first < 0) first = i;
         end
      end
      check({name, "_nbeats"}, gotq.size(), expq.size());
      check({name, "_beat_mismatches"}, nmis, 0);
      if (first >= 0) check({name, "_first_bad_beat"}, gotq[first], expq[first]);
      check({name, "_stat_ok"}, stat_ok, exp_ok);
      check({name, "_stat_err"}, stat_err, exp_err);
      check({name, "_stat_drop"}, stat_drop, exp_drop);
      check({name, "_idle_low"}, idle_viol, 0);
      gotq.delete(); expq.delete(); gcyc.delete();
      idle_viol = 0;
   endtask

   initial begin
      int k;
      logic [7:0] rb[$];
      bit re[$];

      pulse_reset();

      // good 60-byte payload frame, first-beat latency
      build_frame(7, 60, 1, -1);
      send_burst();
      repeat (8) @(negedge clk);
      check("t1_latency", (gcyc.size() > 0) ? gcyc[0] : -1, first_cyc + 6);
      check("t1_beats", gotq.size(), 60);
      check("t1_ok", stat_ok, 1);
      checkpoint("t1");

      pulse_reset();
      build_frame(7, 60, 0, -1);
      send_burst();
      checkpoint("t2_fcs");

      pulse_reset();
      build_frame(7, 60, 1, 9);
      send_burst();
      checkpoint("t3_er");

      pulse_reset();
      build_frame(7, 0, 1, -1);
      void'(bq.pop_back()); void'(erq.pop_back());
      send_burst();
      checkpoint("t4_len3");

      pulse_reset();
      build_frame(7, 36, 1, -1);
      send_burst();
      checkpoint("t5_runt");
      build_frame(7, 59, 1, -1);
      send_burst();
      build_frame(7, 1, 1, -1);
      send_burst();
      build_frame(1, 1518, 1, -1);
      send_burst();
      checkpoint("t5_bounds");

      pulse_reset();
      build_frame(7, 1596, 1, -1);
      send_burst();
      build_frame(7, 60, 1, -1);
      send_burst();
      checkpoint("t6_long");

      pulse_reset();
      bq.delete(); erq.delete(); post_start = -1;
      bq.push_back(8'h55); bq.push_back(8'h55); bq.push_back(8'h12);
      repeat (3) erq.push_back(0);
      repeat (20) begin bq.push_back(8'($urandom)); erq.push_back(0); end
      send_burst();
      checkpoint("t7_badpre");
      pulse_reset();
      build_frame(16, 20, 1, -1);
      send_burst();
      checkpoint("t7_longpre");

      // reset pulsed mid-payload with dv held high
      pulse_reset();
      build_frame(7, 60, 1, -1);
      k = 28;
      for (int i = 0; i < bq.size(); i++) begin
         @(negedge clk);
         if (i == k + 3) rst = 1'b0;
         dv = 1'b1; rxd = bq[i]; er = erq[i];
         if (i == k) begin
            #1 rst = 1'b1;
            #1 check("t8_rst_async", {m_tvalid, m_tlast, m_tuser, m_tdata, stat_ok, stat_err, stat_drop}, 0);
            clear_exp();
         end
         if (i >= k + 3) begin rb.push_back(bq[i]); re.push_back(erq[i]); end
      end
      model_burst(rb, re);
      @(negedge clk);
      dv = 1'b0;
      build_frame(7, 60, 1, -1);
      send_burst();
      checkpoint("t8_rst_mid");

      // randomized bursts; counters run into saturation
      pulse_reset();
      for (int f = 0; f < 40; f++) begin
         int kind = $urandom_range(0, 9);
         int npre = $urandom_range(1, 15);
         int nb   = $urandom_range(1, 80);
         case (kind)
            0, 1, 2, 3, 4: build_frame(npre, nb, 1, -1);
            5: build_frame(npre, nb, 0, -1);
            6: build_frame(npre, nb, 1, $urandom_range(0, nb + 3));
            7: begin
               build_frame(npre, 0, 1, -1);
               repeat ($urandom_range(0, 4)) begin void'(bq.pop_back()); void'(erq.pop_back()); end
            end
            8: build_frame($urandom_range(16, 18), nb, 1, -1);
            default: begin
               int p;
               build_frame(npre, nb, 1, -1);
               p = $urandom_range(0, npre);
               if ($urandom_range(0, 1) == 1) bq[p] = 8'h12;
               else erq[p] = 1;
            end
         endcase
         send_burst();
         if (f % 5 == 4) checkpoint("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
